// File: rtl/btn_event_counter.sv
// Button synchronizer/debouncer, per-button press counters and seconds counter packed into a 128-bit hex display word.
// Optional autorepeat of held buttons is compiled in with `define BTN_EVENT_AUTOREPEAT_EN.
module btn_event_counter #(
  parameter int C_btn_bits      = 7,
  parameter int C_debounce_bits = 16,
  parameter int C_clk_hz        = 25000000,
  parameter int C_repeat_cycles = 12500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [C_btn_bits-1:0] btn,
  input  logic                  clear,
  output logic [C_btn_bits-1:0] pressed,
  output logic [C_btn_bits-1:0] press_pulse,
  output logic [127:0]          data
);

  localparam int PRESC_W = (C_clk_hz > 1) ? $clog2(C_clk_hz) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(C_clk_hz - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = 1;
  localparam logic [C_debounce_bits-1:0] DB_ONE = 1;
  localparam int NCNT = (C_btn_bits < 7) ? C_btn_bits : 7;

  logic [C_btn_bits-1:0]      sync1, sync2;
  logic [C_debounce_bits-1:0] cnt [C_btn_bits];
  logic [C_btn_bits-1:0]      rise, pulse_next;
  logic [7:0]                 press_cnt [C_btn_bits];
  logic [PRESC_W-1:0]         presc;
  logic                       tick;
  logic [63:0]                seconds;
  logic [127:0]               data_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // A level is accepted only after it has differed from pressed for 2^C_debounce_bits cycles in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pressed <= '0;
      for (int i = 0; i < C_btn_bits; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < C_btn_bits; i++) begin
        if (sync2[i] == pressed[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != '1) begin
          cnt[i] <= cnt[i] + DB_ONE;
        end else begin
          pressed[i] <= sync2[i];
          cnt[i]     <= '0;
        end
      end
    end
  end

  always_comb begin
    rise = '0;
    for (int i = 0; i < C_btn_bits; i++)
      rise[i] = sync2[i] && !pressed[i] && (cnt[i] == '1);
  end

`ifdef BTN_EVENT_AUTOREPEAT_EN
  localparam int REP_W = (C_repeat_cycles > 1) ? $clog2(C_repeat_cycles + 1) : 1;
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(C_repeat_cycles - 1);
  localparam logic [REP_W-1:0] REP_ONE = 1;

  logic [REP_W-1:0]      rep_cnt [C_btn_bits];
  logic [C_btn_bits-1:0] rep_hit;

  // Counter is 0 in the initial pulse cycle, so repeats land every C_repeat_cycles after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < C_btn_bits; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < C_btn_bits; i++) begin
        if (!pressed[i] || rep_cnt[i] == REP_MAX) rep_cnt[i] <= '0;
        else                                      rep_cnt[i] <= rep_cnt[i] + REP_ONE;
      end
    end
  end

  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < C_btn_bits; i++)
      rep_hit[i] = pressed[i] && (rep_cnt[i] == REP_MAX);
  end

  assign pulse_next = rise | rep_hit;
`else
  assign pulse_next = rise;
`endif

  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_pulse <= '0;
      presc       <= '0;
      seconds     <= '0;
      for (int i = 0; i < C_btn_bits; i++) press_cnt[i] <= '0;
    end else begin
      press_pulse <= pulse_next;
      // clear wins over a coincident pulse or tick.
      if (clear) begin
        presc   <= '0;
        seconds <= '0;
      end else if (tick) begin
        presc   <= '0;
        seconds <= seconds + 64'd1;
      end else begin
        presc <= presc + PRESC_ONE;
      end
      for (int i = 0; i < C_btn_bits; i++) begin
        if (clear)               press_cnt[i] <= '0;
        else if (press_pulse[i]) press_cnt[i] <= press_cnt[i] + 8'd1;
      end
    end
  end

  always_comb begin
    data_next = '0;
    for (int i = 0; i < NCNT; i++) data_next[8*i +: 8] = press_cnt[i];
    data_next[56 +: C_btn_bits] = pressed;
    data_next[127:64] = seconds;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data <= '0;
    else       data <= data_next;
  end

endmodule
